// File: rtl/seg7_word_decoder.sv
// seg7_word_decoder
//   Reassembles a hex word from a digit-serial stream of active-low
//   seven-segment patterns (most-significant digit first, frame start marked
//   by seg_sof). Every pattern is checked against the 16 legal glyphs. A
//   clean frame updates word_out with a one-cycle word_valid pulse. A frame
//   holding any illegal glyph pulses frame_err instead. A new SOF before the
//   frame completes pulses frame_abort and restarts collection on that beat.
//
// Ports
//   clk          clock, posedge
//   reset_n      async active-low reset
//   seg_valid    a pattern is present on seg_in
//   seg_sof      with seg_valid: this is digit 0 of a frame
//   seg_in[6:0]  segment pattern, bit0=a .. bit6=g, 0 = lit
//   word_out     last good word, digit 0 in the top nibble
//   word_valid   pulse: word_out was updated
//   frame_err    pulse: a frame completed with at least one illegal pattern
//   frame_abort  pulse: SOF arrived while a frame was being collected
//   busy         high while collecting a frame
module seg7_word_decoder #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    seg_valid,
  input  logic                    seg_sof,
  input  logic [6:0]              seg_in,
  output logic [4*NUM_DIGITS-1:0] word_out,
  output logic                    word_valid,
  output logic                    frame_err,
  output logic                    frame_abort,
  output logic                    busy
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    asm_q, asm_d;
  logic            bad_q, bad_d;
  logic [W-1:0]    word_q, word_d;
  logic            wv_q, wv_d;
  logic            err_q, err_d;
  logic            abort_q, abort_d;
  logic            busy_q, busy_d;

  // {legal, nibble}; illegal patterns decode to nibble 0 so they never leak
  // into the assembly register.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40: r = {1'b1, 4'h0};
      7'h79: r = {1'b1, 4'h1};
      7'h24: r = {1'b1, 4'h2};
      7'h30: r = {1'b1, 4'h3};
      7'h19: r = {1'b1, 4'h4};
      7'h12: r = {1'b1, 4'h5};
      7'h02: r = {1'b1, 4'h6};
      7'h78: r = {1'b1, 4'h7};
      7'h00: r = {1'b1, 4'h8};
      7'h10: r = {1'b1, 4'h9};
      7'h08: r = {1'b1, 4'hA};
      7'h03: r = {1'b1, 4'hB};
      7'h46: r = {1'b1, 4'hC};
      7'h21: r = {1'b1, 4'hD};
      7'h06: r = {1'b1, 4'hE};
      7'h0E: r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  logic [4:0]   dec;
  logic         legal;
  logic [W-1:0] nib_w;
  logic         finish;

  assign dec   = seg_decode(seg_in);
  assign legal = dec[4];
  assign nib_w = W'(dec[3:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    bad_d   = bad_q;
    word_d  = word_q;
    wv_d    = 1'b0;
    err_d   = 1'b0;
    abort_d = 1'b0;
    finish  = 1'b0;

    case (state_q)
      IDLE: begin
        if (seg_valid && seg_sof) begin
          asm_d = nib_w;
          bad_d = ~legal;
          cnt_d = CW'(1);
          // A one-digit frame completes on its own SOF beat.
          if (NUM_DIGITS == 1) finish = 1'b1;
          else                 state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (seg_valid) begin
          if (seg_sof) begin
            // Drop the partial frame; this beat is digit 0 of the next one.
            abort_d = 1'b1;
            asm_d   = nib_w;
            bad_d   = ~legal;
            cnt_d   = CW'(1);
          end else begin
            asm_d = (asm_q << 4) | nib_w;
            bad_d = bad_q | ~legal;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NUM_DIGITS - 1)) finish = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      if (bad_d) begin
        err_d = 1'b1;
      end else begin
        word_d = asm_d;
        wv_d   = 1'b1;
      end
      state_d = IDLE;
      bad_d   = 1'b0;
      cnt_d   = '0;
    end

    busy_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      bad_q   <= 1'b0;
      word_q  <= '0;
      wv_q    <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      bad_q   <= bad_d;
      word_q  <= word_d;
      wv_q    <= wv_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
    end
  end

  assign word_out    = word_q;
  assign word_valid  = wv_q;
  assign frame_err   = err_q;
  assign frame_abort = abort_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_seg7_word_decoder.sv
module tb_seg7_word_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        seg_valid = 1'b0;
  logic        seg_sof = 1'b0;
  logic [6:0]  seg_in = 7'h7F;

  logic [15:0] w4;
  logic        wv4, fe4, fa4, bz4;
  logic [3:0]  w1;
  logic        wv1, fe1, fa1, bz1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_word_decoder #(.NUM_DIGITS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .seg_valid(seg_valid), .seg_sof(seg_sof),
    .seg_in(seg_in), .word_out(w4), .word_valid(wv4), .frame_err(fe4),
    .frame_abort(fa4), .busy(bz4));

  seg7_word_decoder #(.NUM_DIGITS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .seg_valid(seg_valid), .seg_sof(seg_sof),
    .seg_in(seg_in), .word_out(w1), .word_valid(wv1), .frame_err(fe1),
    .frame_abort(fa1), .busy(bz1));

  // Glyph table: index is the hex value shown.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model, index 0 = 4-digit instance, index 1 = 1-digit instance.
  int          m_n      [2] = '{4, 1};
  bit          m_active [2];
  int          m_cnt    [2];
  bit          m_bad    [2];
  int unsigned m_acc    [2];
  int unsigned m_word   [2];
  bit          m_wv     [2];
  bit          m_fe     [2];
  bit          m_fa     [2];

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (glyph[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_active[m] = 0; m_cnt[m] = 0; m_bad[m] = 0; m_acc[m] = 0;
      m_word[m] = 0; m_wv[m] = 0; m_fe[m] = 0; m_fa[m] = 0;
    end
  endtask

  task automatic model_step(input bit v, input bit sof, input logic [6:0] s);
    int d;
    d = lookup(s);
    for (int m = 0; m < 2; m++) begin
      m_wv[m] = 0; m_fe[m] = 0; m_fa[m] = 0;
      if (v && (sof || m_active[m])) begin
        if (sof) begin
          if (m_active[m]) m_fa[m] = 1;
          m_acc[m] = 0; m_cnt[m] = 0; m_bad[m] = 0; m_active[m] = 1;
        end
        m_acc[m] = m_acc[m] * 16 + ((d < 0) ? 0 : d);
        if (d < 0) m_bad[m] = 1;
        m_cnt[m]++;
        if (m_cnt[m] == m_n[m]) begin
          if (m_bad[m]) m_fe[m] = 1;
          else begin m_word[m] = m_acc[m]; m_wv[m] = 1; end
          m_active[m] = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " w4.word"},  {16'h0, w4}, m_word[0]);
    check({tag, " w4.wv"},    {31'h0, wv4}, {31'h0, m_wv[0]});
    check({tag, " w4.err"},   {31'h0, fe4}, {31'h0, m_fe[0]});
    check({tag, " w4.abort"}, {31'h0, fa4}, {31'h0, m_fa[0]});
    check({tag, " w4.busy"},  {31'h0, bz4}, {31'h0, m_active[0]});
    check({tag, " w1.word"},  {28'h0, w1}, m_word[1]);
    check({tag, " w1.wv"},    {31'h0, wv1}, {31'h0, m_wv[1]});
    check({tag, " w1.err"},   {31'h0, fe1}, {31'h0, m_fe[1]});
    check({tag, " w1.abort"}, {31'h0, fa1}, {31'h0, m_fa[1]});
    check({tag, " w1.busy"},  {31'h0, bz1}, {31'h0, m_active[1]});
  endtask

  // Present one beat, clock it, then compare after the edge settles.
  task automatic beat(input string tag, input bit v, input bit sof, input logic [6:0] s);
    seg_valid = v; seg_sof = sof; seg_in = s;
    @(posedge clk); #1;
    model_step(v, sof, s);
    check_all(tag);
  endtask

  task automatic frame4(input string tag, input logic [6:0] a, input logic [6:0] b,
                        input logic [6:0] c, input logic [6:0] d);
    beat(tag, 1, 1, a); beat(tag, 1, 0, b); beat(tag, 1, 0, c); beat(tag, 1, 0, d);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Legal frame: 5,8,A,b
    frame4("legal", 7'h12, 7'h00, 7'h08, 7'h03);
    beat("legal.after", 0, 0, 7'h7F);
    check("legal.word_const", {16'h0, w4}, 32'h58AB);

    // Gaps between digits, then back-to-back frame
    beat("gap", 1, 1, glyph[1]); beat("gap", 0, 0, 7'h7F);
    beat("gap", 1, 0, glyph[2]); beat("gap", 0, 1, glyph[9]);
    beat("gap", 1, 0, glyph[3]); beat("gap", 0, 0, 7'h7F);
    beat("gap", 1, 0, glyph[4]);
    check("gap.word_const", {16'h0, w4}, 32'h1234);
    frame4("b2b", 7'h0E, 7'h0E, 7'h0E, 7'h0E);
    check("b2b.word_const", {16'h0, w4}, 32'hFFFF);

    // Illegal pattern in frame
    frame4("illegal", 7'h40, 7'h7F, 7'h40, 7'h40);
    check("illegal.err_const", {31'h0, fe4}, 32'h1);
    beat("illegal.after", 0, 0, 7'h7F);

    // Abort then full frame 3,4,5,6
    beat("abort", 1, 1, 7'h79); beat("abort", 1, 0, 7'h24);
    beat("abort", 1, 1, 7'h30);
    check("abort.pulse_const", {31'h0, fa4}, 32'h1);
    beat("abort", 1, 0, 7'h19); beat("abort", 1, 0, 7'h12); beat("abort", 1, 0, 7'h02);
    check("abort.word_const", {16'h0, w4}, 32'h3456);

    // Idle noise without SOF
    beat("noise", 1, 0, 7'h40); beat("noise", 1, 0, 7'h79);

    // Reset mid-frame
    beat("rst", 1, 1, 7'h79); beat("rst", 1, 0, 7'h24);
    seg_valid = 0; seg_sof = 0;
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all("rst.async");
    @(posedge clk); #1;
    reset_n = 1'b1;
    beat("rst.tail", 1, 0, 7'h30); beat("rst.tail", 1, 0, 7'h19);
    beat("rst.tail", 0, 0, 7'h7F);

    // One-digit instance: SOF beats with F, then blank
    beat("n1", 1, 1, 7'h0E); beat("n1", 1, 1, 7'h0E);
    check("n1.word_const", {28'h0, w1}, 32'hF);
    beat("n1", 1, 1, 7'h7F);
    check("n1.err_const", {31'h0, fe1}, 32'h1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit v, sof;
      logic [6:0] s;
      v   = ($urandom_range(0, 9) < 7);
      sof = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 9) < 8) s = glyph[$urandom_range(0, 15)];
      else                          s = 7'($urandom());
      beat("rand", v, sof, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/seg7_word_decoder.md
# seg7_word_decoder

Receive side of the seven-segment digit path: accepts a digit-serial stream of active-low seven-segment patterns, as produced by the team's hex-to-segment encoder, and reassembles the hex word they represent. A frame is NUM_DIGITS patterns, most-significant digit first, marked by a start-of-frame strobe. The block validates every pattern and publishes a complete word with a one-cycle valid pulse. It sits between the display-drive path and any logic that must read back what the HEX displays show, such as a self-check or loopback bench.

## Interface
- NUM_DIGITS, 4, digits per frame; word width is 4*NUM_DIGITS; legal range 1..8.
- clk  in  1  single clock; all logic is posedge.
- reset_n  in  1  asynchronous, active-low reset.
- seg_valid  in  1  a pattern is presented on seg_in this cycle.
- seg_sof  in  1  qualifies seg_valid; this pattern is the first (most-significant) digit of a frame.
- seg_in  in  7  segment pattern; bit0 = a … bit6 = g; 0 = lit.
- word_out  out  4*NUM_DIGITS  last successfully decoded word; digit 0 (first received) lands in the top nibble.
- word_valid  out  1  one-cycle pulse: word_out was updated.
- frame_err  out  1  one-cycle pulse: a frame completed but contained at least one illegal pattern.
- frame_abort  out  1  one-cycle pulse: a new seg_sof arrived before the current frame completed.
- busy  out  1  high while in the COLLECT state.

## Operation
- Decode table (seg_in hex → nibble):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F
  - Any other value, including blank 7F, is illegal.
- FSM has two states, IDLE and COLLECT, with an internal digit counter cnt (0..NUM_DIGITS-1), a shift/assembly register, and a sticky bad flag.
- IDLE:
  - A beat with seg_valid=1 and seg_sof=1 loads digit 0 and sets cnt=1.
  - bad is set if the pattern is illegal.
  - Go to COLLECT. If NUM_DIGITS=1, the frame instead completes immediately (see frame end below).
  - A beat with seg_valid=1 and seg_sof=0 is ignored with no pulse.
  - seg_valid=0 holds state.
- COLLECT:
  - seg_valid=1 with seg_sof=0 shifts the decoded nibble into the assembly register, ORs its illegal flag into bad, and increments cnt.
  - seg_valid=0 holds state; there is no timeout.
- Frame end (the beat that accepts digit NUM_DIGITS-1):
  - If bad=0: word_out ← assembled word and word_valid pulses.
  - If bad=1: word_out is unchanged and frame_err pulses.
  - In either case, return to IDLE and clear bad.
- seg_sof in COLLECT:
  - frame_frame_abort pulses and the partial frame is discarded without updating word_out.
  - The same beat starts a new frame as digit 0 (cnt=1, bad = that digit's illegality).
  - Remain in COLLECT.
- Illegal nibbles are stored as 0 in the assembly register; they are never visible on word_out.
- word_valid and frame_err are mutually exclusive. frame_abort may coincide with neither, because an abort beat is never a completion beat.

## Timing
- All outputs are registered.
- Reset values: word_out=0, word_valid=0, frame_err=0, frame_abort=0, busy=0; state IDLE, cnt=0, bad=0.
- Latency: word_valid / frame_err assert in the cycle after the clock edge that accepted the last digit, and last exactly one cycle.
- Back-to-back frames are supported: seg_sof may arrive on the beat directly after a frame-completing beat, with no dead cycle.
- Throughput: one digit per cycle.
- busy is high from the edge after a first digit is accepted until the edge that accepts the last digit.
- Asserting reset_n low mid-frame immediately clears all state and outputs. A partial frame is lost, with no pulse after release.
- seg_sof is ignored when seg_valid=0.

## Test plan
- **Legal frame.** After reset, send patterns 12,00,08,03 (SOF on the first) on consecutive cycles. Required: word_out=16'h58Ab, word_valid high for 1 cycle, one cycle after the 4th beat; busy low afterwards.
- **Gaps plus back-to-back frames.** Send 1,2,3,4 with seg_valid=0 gaps between digits, then immediately send SOF frame F,F,F,F. Required: first word 16'h1234, then 16'hFFFF, with no missed digit.
- **Illegal pattern.** Send 40,7F,40,40. Required: frame_err pulses once, word_valid stays 0, and word_out keeps its previous value.
- **Abort.** Send SOF 79,24, then SOF 30,19,12,02. Required: frame_abort pulses on the second SOF; word_valid follows with word_out=16'h3456.
- **Idle noise and reset.**
  - seg_valid without SOF in IDLE: no output change.
  - Assert reset_n low after 2 digits of a frame: word_out=0, busy=0.
  - Complete the 2 remaining digits after reset release: no pulse.
- **NUM_DIGITS=1 instance.**
  - Each SOF beat with 0E: word_out=4'hF, word_valid pulse on every beat.
  - A beat with 7F: frame_err.
